// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the TX state encoding, the default baud divisor width, and the
// per-frame configuration that is captured when each word is loaded.
package uart_pkg;

    localparam int BAUD_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic two_stop;
    } frame_cfg_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Bundle between the TX serializer, the TX FIFO read port, the runtime
// configuration and the serial pin.
//   slave  : serializer side (FIFO head word/empty flag and config in;
//            pop strobe, tx line, busy and done out)
//   master : driver side (FIFO model, config registers, line monitor)
interface uart_tx_serializer_if
    import uart_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int BAUD_W = BAUD_W_DEF
);
    logic [WIDTH-1:0]  fifo_data_i;
    logic              fifo_empty_i;
    logic              fifo_pop_o;
    logic [BAUD_W-1:0] baud_div_i;
    logic              parity_en_i;
    logic              parity_odd_i;
    logic              two_stop_i;
    logic              tx_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  fifo_data_i, fifo_empty_i, baud_div_i,
               parity_en_i, parity_odd_i, two_stop_i,
        output fifo_pop_o, tx_o, busy_o, done_o
    );

    modport master (
        output fifo_data_i, fifo_empty_i, baud_div_i,
               parity_en_i, parity_odd_i, two_stop_i,
        input  fifo_pop_o, tx_o, busy_o, done_o
    );
endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period timer: loadable down-counter.
//   clk, reset : clock and async active-high reset
//   load_i     : reload the counter with div_i (start of a bit)
//   div_i      : cycles per bit minus 1
//   bit_end_o  : high during the last cycle of the current bit
module uart_tx_baud_cnt #(
    parameter int BAUD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [BAUD_W-1:0] div_i,
    output logic              bit_end_o
);
    logic [BAUD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = div_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - BAUD_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bit_end_o = (cnt_q == '0);
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: drains the TX FIFO's show-ahead port and sends
// each word as start bit, LSB-first data, optional parity, 1 or 2 stop bits.
//   clk, reset : clock and async active-high reset
//   bus        : FIFO read port, runtime config, tx line, busy/done status
//
// state     | meaning
// ----------|---------------------------------------------
// ST_IDLE   | line high, waiting for a non-empty FIFO
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bits, LSB first
// ST_PARITY | driving the parity bit
// ST_STOP   | driving stop bit(s) (1)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int BAUD_W = BAUD_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_serializer_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop_q, stop_d;
    logic              par_q, par_d;
    frame_cfg_t        cfg_q, cfg_d;
    logic [BAUD_W-1:0] div_q, div_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end, last_stop, load, cnt_load;

    uart_tx_baud_cnt #(.BAUD_W(BAUD_W)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .div_i     (load ? bus.baud_div_i : div_q),
        .bit_end_o (bit_end)
    );

    // Every bit boundary (and every frame load) restarts the bit timer.
    assign cnt_load = load || (state_q != ST_IDLE && bit_end);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        par_d     = par_q;
        cfg_d     = cfg_q;
        div_d     = div_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        last_stop = (state_q == ST_STOP) && bit_end && !stop_q;
        // Pop is gated by reset so a held reset never drains the FIFO.
        load      = !reset && !bus.fifo_empty_i &&
                    (state_q == ST_IDLE || last_stop);

        case (state_q)
            ST_START: if (bit_end) begin
                state_d = ST_DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                idx_d   = IDX_W'(WIDTH - 1);
            end
            ST_DATA: if (bit_end) begin
                if (idx_q == '0) begin
                    if (cfg_q.parity_en) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q ^ cfg_q.parity_odd;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        stop_d  = cfg_q.two_stop;
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
                stop_d  = cfg_q.two_stop;
            end
            ST_STOP: if (bit_end) begin
                if (stop_q) begin
                    stop_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // A load on the final stop cycle overrides the return to IDLE so the
        // next start bit follows with no idle gap.
        if (load) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shift_d = bus.fifo_data_i;
            par_d   = ^bus.fifo_data_i;
            div_d   = bus.baud_div_i;
            cfg_d   = '{parity_en:  bus.parity_en_i,
                        parity_odd: bus.parity_odd_i,
                        two_stop:   bus.two_stop_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            cfg_q   <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            cfg_q   <= cfg_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.fifo_pop_o = load;
    assign bus.tx_o       = tx_q;
    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.done_o     = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_serializer_if #(.WIDTH(8), .BAUD_W(16)) bus ();

    uart_tx_serializer #(.WIDTH(8), .BAUD_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int pop_t[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.fifo_pop_o === 1'b1) begin
            pop_cnt++;
            pop_t.push_back(cyc);
        end
        if (bus.done_o === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the pop strobe; returns on the negedge where it is seen.
    task automatic wait_pop(input string tag);
        int t = 0;
        @(negedge clk);
        while (bus.fifo_pop_o !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ".pop"}, {31'b0, bus.fifo_pop_o}, 32'd1);
    endtask

    // Checks tx and busy on every cycle of a frame; exp_s lists line bits in time order.
    task automatic sample_frame(input string tag, input string exp_s, input int div);
        int len;
        logic e;
        len = exp_s.len() * (div + 1);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = (exp_s.getc(k / (div + 1)) == 8'h31);
            chk($sformatf("%s.tx[%0d]", tag, k), {31'b0, bus.tx_o}, {31'b0, e});
            chk($sformatf("%s.busy[%0d]", tag, k), {31'b0, bus.busy_o}, 32'd1);
        end
    endtask

    // Called at posedge+1 with the DUT idle; ends at posedge+1 with the DUT idle.
    task automatic run_frame(input string tag, input logic [7:0] word, input logic [15:0] div,
                             input logic pen, input logic podd, input logic two,
                             input string exp_s, input logic [15:0] div_after);
        int p0, d0;
        p0 = pop_cnt;
        d0 = done_cnt;
        bus.fifo_data_i  = word;
        bus.baud_div_i   = div;
        bus.parity_en_i  = pen;
        bus.parity_odd_i = podd;
        bus.two_stop_i   = two;
        bus.fifo_empty_i = 1'b0;
        wait_pop(tag);
        @(posedge clk); #1;
        bus.fifo_empty_i = 1'b1;
        bus.baud_div_i   = div_after;
        bus.parity_en_i  = ~pen;
        bus.parity_odd_i = ~podd;
        bus.two_stop_i   = ~two;
        sample_frame(tag, exp_s, int'(div));
        @(negedge clk);
        chk({tag, ".done"}, {31'b0, bus.done_o}, 32'd1);
        chk({tag, ".idle_busy"}, {31'b0, bus.busy_o}, 32'd0);
        chk({tag, ".idle_tx"}, {31'b0, bus.tx_o}, 32'd1);
        @(posedge clk); #1;
        chk({tag, ".pops"}, pop_cnt - p0, 32'd1);
        chk({tag, ".dones"}, done_cnt - d0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0;

        // 1: reset held with a non-empty FIFO, then release
        reset            = 1'b1;
        bus.fifo_data_i  = 8'h3C;
        bus.fifo_empty_i = 1'b0;
        bus.baud_div_i   = 16'd0;
        bus.parity_en_i  = 1'b0;
        bus.parity_odd_i = 1'b0;
        bus.two_stop_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1.rst_tx", {31'b0, bus.tx_o}, 32'd1);
        chk("t1.rst_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("t1.rst_pop", {31'b0, bus.fifo_pop_o}, 32'd0);
        chk("t1.rst_done", {31'b0, bus.done_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1.first_pop", {31'b0, bus.fifo_pop_o}, 32'd1);
        @(posedge clk); #1;
        bus.fifo_empty_i = 1'b1;
        sample_frame("t1", "0001111001", 0);
        @(negedge clk);
        chk("t1.done", {31'b0, bus.done_o}, 32'd1);
        @(posedge clk); #1;
        chk("t1.pops", pop_cnt, 32'd1);

        // 2: div=3, no parity, 1 stop, 0xA5
        run_frame("t2", 8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, "0101001011", 16'd3);

        // 3: div=1, parity even / odd on 0x07
        run_frame("t3e", 8'h07, 16'd1, 1'b1, 1'b0, 1'b0, "01110000011", 16'd1);
        run_frame("t3o", 8'h07, 16'd1, 1'b1, 1'b1, 1'b0, "01110000001", 16'd1);

        // 4: back-to-back 0x55, 0xAA
        p0 = pop_cnt;
        d0 = done_cnt;
        bus.fifo_data_i  = 8'h55;
        bus.baud_div_i   = 16'd3;
        bus.parity_en_i  = 1'b0;
        bus.parity_odd_i = 1'b0;
        bus.two_stop_i   = 1'b0;
        bus.fifo_empty_i = 1'b0;
        wait_pop("t4a");
        @(posedge clk); #1;
        bus.fifo_data_i = 8'hAA;
        sample_frame("t4a", "0101010101", 3);
        @(posedge clk); #1;
        bus.fifo_empty_i = 1'b1;
        sample_frame("t4b", "0010101011", 3);
        @(negedge clk);
        chk("t4.done", {31'b0, bus.done_o}, 32'd1);
        chk("t4.idle_busy", {31'b0, bus.busy_o}, 32'd0);
        @(posedge clk); #1;
        chk("t4.pops", pop_cnt - p0, 32'd2);
        chk("t4.dones", done_cnt - d0, 32'd2);
        chk("t4.pop_gap", pop_t[pop_t.size()-1] - pop_t[pop_t.size()-2], 32'd40);

        // 5: async reset in the middle of the data bits
        d0 = done_cnt;
        bus.fifo_data_i  = 8'hA5;
        bus.baud_div_i   = 16'd3;
        bus.fifo_empty_i = 1'b0;
        wait_pop("t5");
        @(posedge clk); #1;
        bus.fifo_empty_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5.mid_tx", {31'b0, bus.tx_o}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5.async_tx", {31'b0, bus.tx_o}, 32'd1);
        chk("t5.async_busy", {31'b0, bus.busy_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        p0 = pop_cnt;
        repeat (8) @(negedge clk);
        chk("t5.after_tx", {31'b0, bus.tx_o}, 32'd1);
        chk("t5.after_busy", {31'b0, bus.busy_o}, 32'd0);
        @(posedge clk); #1;
        chk("t5.no_pop", pop_cnt - p0, 32'd0);
        chk("t5.no_done", done_cnt - d0, 32'd0);

        // 6: div=0, two stop bits, 0xFF; divisor changed mid-frame
        run_frame("t6", 8'hFF, 16'd0, 1'b0, 1'b0, 1'b1, "01111111111", 16'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
